// File: rtl/modop_pkg.sv
// Shared types and helpers for the modop library: pipeline stage configuration,
// latency and modulus-split width.
package modop_pkg;

  localparam int unsigned ModsubDefaultLogq  = 64;
  localparam int unsigned ModsubDefaultLogqh = 47;

  typedef struct packed {
    logic ff_in;
    logic ff_sub;
    logic ff_out;
  } modsub_params_t;

  // Pipeline depth from input transfer to valid_o with no stalls.
  function automatic int unsigned modsub_lat(modsub_params_t p);
    return 32'(p.ff_in) + 32'(p.ff_sub) + 32'(p.ff_out);
  endfunction

  // Number of low bits of q below qH; q = {qH, W'(1)}.
  function automatic int unsigned modsub_w(int unsigned logq, int unsigned logqh);
    return logq - logqh;
  endfunction

  localparam int unsigned ModsubDefaultW = modsub_w(ModsubDefaultLogq, ModsubDefaultLogqh);

endpackage

// File: rtl/modsub_if.sv
// Operand/result handshake bundle for modsub: input side (valid_i/ready_o) and
// output side (valid_o/ready_i) with their data and sideband.
interface modsub_if #(
  parameter int unsigned LOGQ  = 64,
  parameter int unsigned LOGQH = 47,
  parameter int unsigned TAGW  = 8
);

  logic             valid_i;
  logic             ready_o;
  logic [LOGQ-1:0]  A;
  logic [LOGQ-1:0]  B;
  logic [LOGQH-1:0] qH;
  logic [TAGW-1:0]  tag_i;

  logic             valid_o;
  logic             ready_i;
  logic [LOGQ-1:0]  C;
  logic [TAGW-1:0]  tag_o;
  logic             range_err_o;

  modport slave (
    input  valid_i, A, B, qH, tag_i, ready_i,
    output ready_o, valid_o, C, tag_o, range_err_o
  );

  modport master (
    output valid_i, A, B, qH, tag_i, ready_i,
    input  ready_o, valid_o, C, tag_o, range_err_o
  );

endinterface

// File: rtl/modsub_stage.sv
// One elastic pipeline slice {valid, data}; EN = 0 degenerates to a plain wire
// so the same slice can be configured in or out of the pipeline.
module modsub_stage #(
  parameter int unsigned WIDTH = 8,
  parameter bit          EN    = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] data_d, data_q;

  always_comb begin
    if (EN) begin
      // Load when empty or when the current content leaves this cycle.
      in_ready_o  = !valid_q || out_ready_i;
      out_valid_o = valid_q;
      out_data_o  = data_q;
    end else begin
      in_ready_o  = out_ready_i;
      out_valid_o = in_valid_i;
      out_data_o  = in_data_i;
    end

    valid_d = valid_q;
    data_d  = data_q;
    if (EN && in_ready_o) begin
      valid_d = in_valid_i;
      // Data is only replaced by a real transfer so a drained slice keeps its last value.
      if (in_valid_i) begin
        data_d = in_data_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/modsub.sv
// Pipelined modular subtractor C = (A - B) mod q, q = {qH, W'(1)}, with full valid/ready
// backpressure. Define MODSUB_RANGE_CHECK_EN to flag A >= q or B >= q on range_err_o.
module modsub
  import modop_pkg::*;
#(
  parameter int unsigned LOGQ   = 64,
  parameter int unsigned LOGQH  = 47,
  parameter int unsigned TAGW   = 8,
  parameter int unsigned FF_IN  = 1,
  parameter int unsigned FF_SUB = 1,
  parameter int unsigned FF_OUT = 1
) (
  input logic     clk,
  input logic     rst_n,
  modsub_if.slave bus
);

  localparam int unsigned W = modsub_w(LOGQ, LOGQH);
  localparam logic [W-1:0] QLow = W'(1);

  localparam modsub_params_t Cfg = '{
    ff_in:  (FF_IN != 0),
    ff_sub: (FF_SUB != 0),
    ff_out: (FF_OUT != 0)
  };

  // Slice payloads: {A, B, qH, tag}, {D, Dq low, err, tag}, {C, err, tag}.
  localparam int unsigned S1W = 2 * LOGQ + LOGQH + TAGW;
  localparam int unsigned S2W = 2 * LOGQ + 2 + TAGW;
  localparam int unsigned S3W = LOGQ + 1 + TAGW;

  logic           s1_valid, s1_ready;
  logic [S1W-1:0] s1_in, s1_data;
  logic           s2_valid, s2_ready;
  logic [S2W-1:0] s2_in, s2_data;
  logic           s3_valid;
  logic [S3W-1:0] s3_in, s3_data;
  logic           in_ready, out_valid;

  logic [LOGQ-1:0]  s1_a, s1_b, q;
  logic [LOGQH-1:0] s1_qh;
  logic [TAGW-1:0]  s1_tag, s2_tag;
  logic [LOGQ:0]    d, s2_d;
  logic [LOGQ-1:0]  dq_lo, s2_dq_lo, c;
  logic             err, s2_err;

  assign s1_in = {bus.A, bus.B, bus.qH, bus.tag_i};

  modsub_stage #(
    .WIDTH(S1W),
    .EN   (Cfg.ff_in)
  ) u_stage_in (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (bus.valid_i),
    .in_ready_o (in_ready),
    .in_data_i  (s1_in),
    .out_valid_o(s1_valid),
    .out_ready_i(s1_ready),
    .out_data_o (s1_data)
  );

  assign {s1_a, s1_b, s1_qh, s1_tag} = s1_data;

  always_comb begin
    q     = {s1_qh, QLow};
    d     = {1'b0, s1_a} - {1'b0, s1_b};
    // Only the low LOGQ bits of D + q are ever selected.
    dq_lo = d[LOGQ-1:0] + q;
    err   = 1'b0;
`ifdef MODSUB_RANGE_CHECK_EN
    err   = (s1_a >= q) || (s1_b >= q);
`endif
  end

  assign s2_in = {d, dq_lo, err, s1_tag};

  modsub_stage #(
    .WIDTH(S2W),
    .EN   (Cfg.ff_sub)
  ) u_stage_sub (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (s1_valid),
    .in_ready_o (s1_ready),
    .in_data_i  (s2_in),
    .out_valid_o(s2_valid),
    .out_ready_i(s2_ready),
    .out_data_o (s2_data)
  );

  assign {s2_d, s2_dq_lo, s2_err, s2_tag} = s2_data;

  // A borrow out of the subtract means the result wrapped; add q back once.
  assign c     = s2_d[LOGQ] ? s2_dq_lo : s2_d[LOGQ-1:0];
  assign s3_in = {c, s2_err, s2_tag};

  modsub_stage #(
    .WIDTH(S3W),
    .EN   (Cfg.ff_out)
  ) u_stage_out (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (s2_valid),
    .in_ready_o (s2_ready),
    .in_data_i  (s3_in),
    .out_valid_o(s3_valid),
    .out_ready_i(bus.ready_i),
    .out_data_o (s3_data)
  );

  assign out_valid = s3_valid;

  assign bus.ready_o                          = in_ready;
  assign bus.valid_o                          = out_valid;
  assign {bus.C, bus.range_err_o, bus.tag_o}  = s3_data;

endmodule

// File: tb/tb_modsub.sv
// Scoreboard bench for modsub (LOGQ=8, LOGQH=4, qH=0xD, q=209): pipelined instance plus
// a fully combinational instance; range_err expectations follow MODSUB_RANGE_CHECK_EN.
module tb_modsub;
  import modop_pkg::*;

  localparam int unsigned LOGQ  = 8;
  localparam int unsigned LOGQH = 4;
  localparam int unsigned TAGW  = 8;
  localparam logic [LOGQH-1:0] QH = 4'hD;
  localparam int Q = (int'(QH) << (LOGQ - LOGQH)) + 1;
  localparam modsub_params_t Cfg = '{ff_in: 1'b1, ff_sub: 1'b1, ff_out: 1'b1};
  localparam int Lat = int'(modsub_lat(Cfg));

  typedef struct packed {
    logic [LOGQ-1:0] c;
    logic [TAGW-1:0] tag;
    logic            err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t exp_q[$];
  exp_t comb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  modsub_if #(.LOGQ(LOGQ), .LOGQH(LOGQH), .TAGW(TAGW)) bus ();
  modsub_if #(.LOGQ(LOGQ), .LOGQH(LOGQH), .TAGW(TAGW)) bus0 ();

  modsub #(
    .LOGQ(LOGQ), .LOGQH(LOGQH), .TAGW(TAGW), .FF_IN(1), .FF_SUB(1), .FF_OUT(1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  modsub #(
    .LOGQ(LOGQ), .LOGQH(LOGQH), .TAGW(TAGW), .FF_IN(0), .FF_SUB(0), .FF_OUT(0)
  ) dut0 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus0)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input int a, input int b, input int tag);
    exp_t m;
    int   c;
    c     = (a >= b) ? (a - b) : (a - b + Q);
    m.c   = LOGQ'(c);
    m.tag = TAGW'(tag);
    m.err = 1'b0;
`ifdef MODSUB_RANGE_CHECK_EN
    m.err = (a >= Q) || (b >= Q);
`endif
    return m;
  endfunction

  function automatic exp_t observed();
    exp_t g;
    g.c   = bus.C;
    g.tag = bus.tag_o;
    g.err = bus.range_err_o;
    return g;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks += 5;
    if (bus.valid_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid_o: got %b expected 0", bus.valid_o);
    end
    if (bus.C !== '0) begin
      n_fail++; $display("FAIL reset_C: got %0d expected 0", bus.C);
    end
    if (bus.tag_o !== '0) begin
      n_fail++; $display("FAIL reset_tag_o: got %0d expected 0", bus.tag_o);
    end
    if (bus.range_err_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_range_err: got %b expected 0", bus.range_err_o);
    end
    if (bus.ready_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready_o: got %b expected 1", bus.ready_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    int   da[4] = '{5, 9, 100, 0};
    int   db[4] = '{9, 5, 100, 208};
    int   dc[4] = '{205, 4, 0, 1};
    int   cyc, acc_c, out_c;
    exp_t e, g;
    for (int i = 0; i < 4; i++) begin
      cyc = 0; acc_c = -1; out_c = -1;
      @(posedge clk); #1;
      bus.A = LOGQ'(da[i]); bus.B = LOGQ'(db[i]); bus.tag_i = TAGW'(16 + i); bus.valid_i = 1'b1;
      while (out_c < 0 && cyc < 20) begin
        @(negedge clk);
        if (bus.valid_o && bus.ready_i) begin
          out_c = cyc;
          g = observed();
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL directed_unexpected: got %h expected no output", g);
          end else begin
            e = exp_q.pop_front();
            if (g !== e) begin
              n_fail++; $display("FAIL directed_%0d_result: got %h expected %h", i, g, e);
            end
          end
        end
        if (bus.valid_i && bus.ready_o) begin
          acc_c = cyc;
          e.c = LOGQ'(dc[i]); e.tag = TAGW'(16 + i); e.err = 1'b0;
          exp_q.push_back(e);
        end
        @(posedge clk); #1;
        cyc++;
        if (acc_c >= 0) bus.valid_i = 1'b0;
      end
      n_checks++;
      if (out_c < 0 || (out_c - acc_c) != Lat) begin
        n_fail++;
        $display("FAIL directed_%0d_latency: got %0d expected %0d", i, out_c - acc_c, Lat);
      end
    end
  endtask

  task automatic test_backpressure();
    int   a_v[8], b_v[8];
    int   cyc, sent, got;
    logic held_v, exp_rdy, acc;
    exp_t held, e, g;
    foreach (a_v[i]) begin
      a_v[i] = int'($urandom_range(0, Q - 1));
      b_v[i] = int'($urandom_range(0, Q - 1));
    end
    cyc = 0; sent = 0; got = 0; held_v = 1'b0; held = '0;
    @(posedge clk); #1;
    bus.A = LOGQ'(a_v[0]); bus.B = LOGQ'(b_v[0]); bus.tag_i = '0;
    bus.valid_i = 1'b1; bus.ready_i = 1'b1;
    while (got < 8 && cyc < 60) begin
      @(negedge clk);
      exp_rdy = bus.ready_i || (exp_q.size() < Lat);
      n_checks++;
      if (bus.ready_o !== exp_rdy) begin
        n_fail++; $display("FAIL bp_ready_o cyc %0d: got %b expected %b", cyc, bus.ready_o, exp_rdy);
      end
      g = observed();
      if (bus.valid_o && !bus.ready_i) begin
        if (held_v) begin
          n_checks++;
          if (g !== held) begin
            n_fail++; $display("FAIL bp_stall_hold cyc %0d: got %h expected %h", cyc, g, held);
          end
        end
        held_v = 1'b1; held = g;
      end else begin
        held_v = 1'b0;
      end
      if (bus.valid_o && bus.ready_i) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL bp_unexpected: got %h expected no output", g);
        end else begin
          e = exp_q.pop_front();
          if (g !== e) begin
            n_fail++; $display("FAIL bp_result_%0d: got %h expected %h", got, g, e);
          end
        end
        got++;
      end
      acc = bus.valid_i && bus.ready_o;
      if (acc) begin
        exp_q.push_back(model(a_v[sent], b_v[sent], sent));
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
      if (sent < 8) begin
        bus.A = LOGQ'(a_v[sent]); bus.B = LOGQ'(b_v[sent]); bus.tag_i = TAGW'(sent);
      end else begin
        bus.valid_i = 1'b0;
      end
      bus.ready_i = !(cyc >= 4 && cyc < 9);
    end
    bus.ready_i = 1'b1;
    n_checks++;
    if (got != 8) begin
      n_fail++; $display("FAIL bp_count: got %0d results expected 8", got);
    end
  endtask

  task automatic test_reset_midstream();
    int   cyc, sent, got, acc_c, out_c;
    exp_t e, g;
    sent = 0; cyc = 0;
    @(posedge clk); #1;
    bus.A = LOGQ'(30); bus.B = LOGQ'(40); bus.tag_i = 8'hA0; bus.valid_i = 1'b1;
    while (sent < 3 && cyc < 20) begin
      @(negedge clk);
      if (bus.valid_i && bus.ready_o) begin
        exp_q.push_back(model(30 + sent, 40, 8'hA0 + sent));
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
      bus.A = LOGQ'(30 + sent); bus.tag_i = TAGW'(8'hA0 + sent);
    end
    bus.valid_i = 1'b0;
    n_checks++;
    if (bus.valid_o !== 1'b1) begin
      n_fail++; $display("FAIL rst_pre_valid: got %b expected 1", bus.valid_o);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.valid_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_async_valid: got %b expected 0", bus.valid_o);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    cyc = 0; sent = 0; got = 0; acc_c = -1; out_c = -1;
    @(posedge clk); #1;
    bus.A = LOGQ'(7); bus.B = LOGQ'(3); bus.tag_i = 8'hB0; bus.valid_i = 1'b1;
    while (got < 2 && cyc < 30) begin
      @(negedge clk);
      if (bus.valid_o && bus.ready_i) begin
        if (out_c < 0) out_c = cyc;
        g = observed();
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rst_unexpected: got %h expected no output", g);
        end else begin
          e = exp_q.pop_front();
          if (g !== e) begin
            n_fail++; $display("FAIL rst_result_%0d: got %h expected %h", got, g, e);
          end
        end
        got++;
      end
      if (bus.valid_i && bus.ready_o) begin
        if (acc_c < 0) acc_c = cyc;
        exp_q.push_back(model(7 + sent, 3, 8'hB0 + sent));
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
      if (sent < 2) begin
        bus.A = LOGQ'(7 + sent); bus.tag_i = TAGW'(8'hB0 + sent);
      end else begin
        bus.valid_i = 1'b0;
      end
    end
    n_checks++;
    if (got != 2 || (out_c - acc_c) != Lat) begin
      n_fail++;
      $display("FAIL rst_post_latency: got %0d results, latency %0d expected 2, %0d", got,
               out_c - acc_c, Lat);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.valid_o !== 1'b0) begin
        n_fail++; $display("FAIL rst_extra_output: got valid_o %b expected 0", bus.valid_o);
      end
    end
  endtask

  task automatic test_range();
    int   ra[2] = '{209, 208};
    int   rc[2] = '{209, 208};
`ifdef MODSUB_RANGE_CHECK_EN
    logic re[2] = '{1'b1, 1'b0};
`else
    logic re[2] = '{1'b0, 1'b0};
`endif
    int   cyc, acc_c, out_c;
    exp_t e, g;
    for (int i = 0; i < 2; i++) begin
      cyc = 0; acc_c = -1; out_c = -1;
      @(posedge clk); #1;
      bus.A = LOGQ'(ra[i]); bus.B = '0; bus.tag_i = TAGW'(8'hC0 + i); bus.valid_i = 1'b1;
      while (out_c < 0 && cyc < 20) begin
        @(negedge clk);
        if (bus.valid_o && bus.ready_i) begin
          out_c = cyc;
          g = observed();
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL range_unexpected: got %h expected no output", g);
          end else begin
            e = exp_q.pop_front();
            if (g !== e) begin
              n_fail++; $display("FAIL range_%0d_result: got %h expected %h", i, g, e);
            end
          end
        end
        if (bus.valid_i && bus.ready_o) begin
          acc_c = cyc;
          e.c = LOGQ'(rc[i]); e.tag = TAGW'(8'hC0 + i); e.err = re[i];
          exp_q.push_back(e);
        end
        @(posedge clk); #1;
        cyc++;
        if (acc_c >= 0) bus.valid_i = 1'b0;
      end
      n_checks++;
      if (out_c < 0) begin
        n_fail++; $display("FAIL range_%0d_timeout: got no output expected one", i);
      end
    end
  endtask

  task automatic test_comb();
    int   a, b, t;
    logic v, r;
    exp_t e, g;
    for (int i = 0; i < 1000; i++) begin
      a = int'($urandom_range(0, Q - 1));
      b = int'($urandom_range(0, Q - 1));
      t = int'($urandom_range(0, 255));
      v = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      bus0.A = LOGQ'(a); bus0.B = LOGQ'(b); bus0.tag_i = TAGW'(t);
      bus0.valid_i = v; bus0.ready_i = r;
      comb_q.push_back(model(a, b, t));
      #1;
      e = comb_q.pop_front();
      g.c = bus0.C; g.tag = bus0.tag_o; g.err = bus0.range_err_o;
      n_checks += 3;
      if (g !== e) begin
        n_fail++; $display("FAIL comb_result_%0d: got %h expected %h", i, g, e);
      end
      if (bus0.valid_o !== v) begin
        n_fail++; $display("FAIL comb_valid_%0d: got %b expected %b", i, bus0.valid_o, v);
      end
      if (bus0.ready_o !== r) begin
        n_fail++; $display("FAIL comb_ready_%0d: got %b expected %b", i, bus0.ready_o, r);
      end
      #4;
    end
  endtask

  initial begin
    bus.valid_i  = 1'b0; bus.A  = '0; bus.B  = '0; bus.qH  = QH; bus.tag_i  = '0;
    bus.ready_i  = 1'b1;
    bus0.valid_i = 1'b0; bus0.A = '0; bus0.B = '0; bus0.qH = QH; bus0.tag_i = '0;
    bus0.ready_i = 1'b1;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midstream();
    test_range();
    test_comb();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
